dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: LOCK_MAX, default 16, the maximum number of consecutive cycles a locked owner may hold the memory while the other port waits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 p0_req / p1_req  input  1 each  access request; port 0 = processor core, port 1 = loader/debug.
REQ-005 p0_we / p1_we  input  1 each  1 = write, 0 = read.
REQ-006 p0_lock / p1_lock  input  1 each  request to keep ownership after this access.
REQ-007 p0_addr / p1_addr  input  32 each  byte address.
REQ-008 p0_wdata / p1_wdata  input  32 each  write data.
REQ-009 p0_gnt / p1_gnt  output  1 each  access accepted this cycle (combinational).
REQ-010 p0_rvalid / p1_rvalid  output  1 each  read data valid; registered.
REQ-011 rdata  output  32  registered read data, shared by both ports.
REQ-012 mem_re, mem_we  output  1 each  data-memory read and write enables.
REQ-013 mem_addr, mem_wdata  output  32 each  data-memory address and write data.
REQ-014 mem_rdata  input  32  data-memory combinational read data.

Function
REQ-015 States: IDLE, OWN0, OWN1; at most one grant per cycle; gnt only when the matching req=1.
REQ-016 IDLE, single requester: grant it the same cycle.
REQ-017 IDLE, both requesting: grant the port not granted last (round-robin pointer `last`); after reset `last`=1, so port 0 wins the first tie.
REQ-018 Granted with lock=1: next state OWNn; otherwise next state IDLE; `last` updates to the granted port on every grant.
REQ-019 OWNn: port n has exclusive grant while req=1; the other port's gnt=0.
REQ-020 OWNn exits to IDLE when port n drops req or lock; that cycle's access, if req=1, is still granted.
REQ-021 Lock counter: cleared on entry to OWNn; increments each OWNn cycle in which the other port requests.
REQ-022 At count = LOCK_MAX-1, port n is still granted that cycle; the state is forced to IDLE with `last`=n, so the waiting port wins next cycle.
REQ-023 Mem mux: mem_addr/mem_wdata follow the granted port; mem_we = gnt & we; mem_re = gnt & ~we; when there is no grant, all mem outputs are 0.
REQ-024 Read latency 1: the cycle after a granted read, rdata = the captured mem_rdata and pn_rvalid = 1 for exactly one cycle.
REQ-025 Without a new read, rdata holds its last value; rvalid never asserts for writes.
REQ-026 An ungranted requester holds req/we/addr/wdata/lock stable until granted; the arbiter does not queue requests.
REQ-027 Back-to-back grants to the same or alternating ports need no idle cycle.

Reset
REQ-028 rst=1 at an edge: state=IDLE, `last`=1, lock counter=0, p0_rvalid=p1_rvalid=0, rdata=0.
REQ-029 A read granted in the cycle rst is asserted produces no rvalid.
REQ-030 While rst=1, gnt and mem enables are 0.

Structure
REQ-031 Shared package holds the state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2), the port-index constants and the LOCK_MAX default.
REQ-032 A single sub-module, rr_lock_ctrl (state, `last`, lock counter, grant decode), is natural; the datapath mux and read register stay in dmem_arbiter.

Verification
REQ-033 p0 read addr 0x10, mem word 0xDEADBEEF, p1 idle -> p0_gnt same cycle, mem_re=1, next cycle p0_rvalid=1 with rdata=0xDEADBEEF.
REQ-034 Both request from reset for 4 cycles without lock -> grants alternate p0, p1, p0, p1.
REQ-035 p1 write 0x55 to 0x20 with lock=1 for 3 cycles while p0 requests -> p1 is granted 3 cycles, then p0 is granted on cycle 4.
REQ-036 p1 locked with LOCK_MAX=16 and p0 requesting continuously -> p1 holds exactly 16 grants, then p0 is granted the next cycle.
REQ-037 p0 read granted, rst asserted the following edge -> p0_rvalid stays 0, state IDLE, the next tie goes to p0.
REQ-038 Both writes to the same address the same cycle -> only one mem_we per cycle, the loser is granted next cycle, and memory holds the loser's data.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: state encoding,
// port indices and the default lock limit.
package dmem_arbiter_pkg;

    localparam int NUM_PORTS        = 2;
    localparam int PORT0            = 0;
    localparam int PORT1            = 1;
    localparam int DATA_W           = 32;
    localparam int LOCK_MAX_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the data-memory side of the arbiter.
// master = requesters and memory model, slave = the arbiter itself.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic              p0_req;
    logic              p1_req;
    logic              p0_we;
    logic              p1_we;
    logic              p0_lock;
    logic              p1_lock;
    logic [DATA_W-1:0] p0_addr;
    logic [DATA_W-1:0] p1_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [DATA_W-1:0] p1_wdata;
    logic              p0_gnt;
    logic              p1_gnt;
    logic              p0_rvalid;
    logic              p1_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock,
        output p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
        input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock,
        input  p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
        output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata,
        output mem_re, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_lock_ctrl.sv
// Round-robin grant decode with bounded lock ownership. Grants are
// combinational from the registered state, `last` pointer and lock counter.
module rr_lock_ctrl
    import dmem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] lock,
    output logic [NUM_PORTS-1:0] gnt
);

    // The grant that opens a tenure is one held cycle already, so the counter
    // trips one short of LOCK_MAX-1 to cap the hold at LOCK_MAX cycles.
    localparam int             CNT_W    = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 2);

    arb_state_t           state_reg;
    logic                 last_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [NUM_PORTS-1:0] other_req;
    logic                 owner;
    logic                 owner_active;
    logic                 lock_hit;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_other
        assign other_req[gi] = req[NUM_PORTS-1-gi];
    end

    assign owner        = (state_reg == ST_OWN1);
    assign owner_active = ((state_reg == ST_OWN0) && req[PORT0]) ||
                          ((state_reg == ST_OWN1) && req[PORT1]);
    assign lock_hit     = owner_active && other_req[owner] && (cnt_reg == CNT_LAST);

    // An owner that drops req releases the memory in the same cycle, so the
    // other port is arbitrated exactly as in IDLE.
    always_comb begin
        gnt = '0;
        if (!srst) begin
            if (owner_active)
                gnt[owner] = 1'b1;
            else if (req[PORT0] && (!req[PORT1] || last_reg))
                gnt[PORT0] = 1'b1;
            else if (req[PORT1])
                gnt[PORT1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_IDLE;
            last_reg  <= 1'b1;
            cnt_reg   <= '0;
        end else if (owner_active) begin
            if (other_req[owner])
                cnt_reg <= cnt_reg + 1'b1;
            if (!lock[owner] || lock_hit)
                state_reg <= ST_IDLE;
        end else if (|gnt) begin
            last_reg  <= gnt[PORT1];
            cnt_reg   <= '0;
            state_reg <= !lock[gnt[PORT1]] ? ST_IDLE :
                         (gnt[PORT1] ? ST_OWN1 : ST_OWN0);
        end else begin
            state_reg <= ST_IDLE;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grant control, memory request mux and the
// shared one-cycle read-data register.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] we;
    logic [NUM_PORTS-1:0] lock;
    logic [NUM_PORTS-1:0] gnt;
    logic [NUM_PORTS-1:0] rvalid_reg;
    logic [DATA_W-1:0]    rdata_reg;
    logic [DATA_W-1:0]    mem_addr_next;
    logic [DATA_W-1:0]    mem_wdata_next;

    assign req  = {bus.p1_req,  bus.p0_req};
    assign we   = {bus.p1_we,   bus.p0_we};
    assign lock = {bus.p1_lock, bus.p0_lock};

    rr_lock_ctrl #(.LOCK_MAX(LOCK_MAX)) u_ctrl (
        .clk  (clk),
        .srst (rst),
        .req  (req),
        .lock (lock),
        .gnt  (gnt)
    );

    assign bus.p0_gnt = gnt[PORT0];
    assign bus.p1_gnt = gnt[PORT1];

    // Address and data are zeroed without a grant so the memory sees no stale bus.
    always_comb begin
        mem_addr_next  = '0;
        mem_wdata_next = '0;
        if (gnt[PORT0]) begin
            mem_addr_next  = bus.p0_addr;
            mem_wdata_next = bus.p0_wdata;
        end else if (gnt[PORT1]) begin
            mem_addr_next  = bus.p1_addr;
            mem_wdata_next = bus.p1_wdata;
        end
    end

    assign bus.mem_addr  = mem_addr_next;
    assign bus.mem_wdata = mem_wdata_next;
    assign bus.mem_we    = |(gnt & we);
    assign bus.mem_re    = |(gnt & ~we);

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_reg <= '0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= gnt & ~we;
            if (|(gnt & ~we))
                rdata_reg <= bus.mem_rdata;
        end
    end

    assign bus.p0_rvalid = rvalid_reg[PORT0];
    assign bus.p1_rvalid = rvalid_reg[PORT1];
    assign bus.rdata     = rdata_reg;

endmodule
